// File: rtl/rca_config_loader_if.sv
// rca_config_loader_if: valid/ready config word stream from the fetch unit to the loader
// cfg_valid  word present on cfg_data
// cfg_ready  loader accepts the word this cycle
// cfg_data   [31:29] kind, [28:24] reserved, [23:16] addr, [15:0] data
interface rca_config_loader_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/rca_config_loader.sv
// rca_config_loader: decodes a config word stream into RCA config register-file write strobes
// clk, rst (async, active-low)   clock and reset
// start, rca_id, abort           load control; rca_id latched on start
// grid_busy                      grid executing; first write waits for it to clear
// cfg                            config word stream (slave side)
// *_wr_en, cpu_src_dest_port     one registered write strobe per accepted legal word
// wr_addr, wr_data               entry address/data for the strobe
// rca_sel_issue                  target RCA held from start to next start
// busy, done, cfg_error          load status; cfg_error sticky until next start
module rca_config_loader #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 5,
  parameter int NUM_WRITE_PORTS    = 5,
  parameter int GRID_NUM_ROWS      = 5,
  parameter int NUM_GRID_MUXES     = 64,
  parameter int GRID_MUX_INPUTS    = 16,
  parameter int IO_UNIT_MUX_INPUTS = 16,
  parameter int MAX_CFG_WORDS      = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(NUM_RCAS)-1:0] rca_id,
  input  logic                        abort,
  input  logic                        grid_busy,
  rca_config_loader_if.slave          cfg,
  output logic [$clog2(NUM_RCAS)-1:0] rca_sel_issue,
  output logic                        grid_mux_wr_en,
  output logic                        io_mux_wr_en,
  output logic                        rca_result_mux_wr_en,
  output logic                        cpu_fb_reg_addr_wr_en,
  output logic                        cpu_nfb_reg_addr_wr_en,
  output logic                        rca_io_inp_map_wr_en,
  output logic                        cpu_src_dest_port,
  output logic [7:0]                  wr_addr,
  output logic [15:0]                 wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_error
);
  localparam int CW = $clog2(MAX_CFG_WORDS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_GRID, RUN, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    kind;
  logic [31:0]   a, d;
  logic          legal, accept, full;
  assign kind  = cfg.cfg_data[31:29];
  assign a     = 32'(cfg.cfg_data[23:16]);
  assign d     = 32'(cfg.cfg_data[15:0]);
  assign legal = kind == 3'd0 ? a < NUM_GRID_MUXES && d < GRID_MUX_INPUTS :
                 kind == 3'd1 ? a < GRID_NUM_ROWS && d < IO_UNIT_MUX_INPUTS :
                 kind == 3'd2 ? a < NUM_WRITE_PORTS && d < GRID_NUM_ROWS :
                 kind == 3'd3 ? a < NUM_READ_PORTS && d < 32 :
                 kind == 3'd6 ? d < 2 ** GRID_NUM_ROWS :
                 a < NUM_WRITE_PORTS && d < 32;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign full          = cnt == CW'(MAX_CFG_WORDS);
  assign cfg.cfg_ready = state == RUN;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      rca_sel_issue          <= '0;
      grid_mux_wr_en         <= 1'b0;
      io_mux_wr_en           <= 1'b0;
      rca_result_mux_wr_en   <= 1'b0;
      cpu_fb_reg_addr_wr_en  <= 1'b0;
      cpu_nfb_reg_addr_wr_en <= 1'b0;
      rca_io_inp_map_wr_en   <= 1'b0;
      cpu_src_dest_port      <= 1'b0;
      wr_addr                <= '0;
      wr_data                <= '0;
      done                   <= 1'b0;
      cfg_error              <= 1'b0;
    end else begin
      grid_mux_wr_en         <= 1'b0;
      io_mux_wr_en           <= 1'b0;
      rca_result_mux_wr_en   <= 1'b0;
      cpu_fb_reg_addr_wr_en  <= 1'b0;
      cpu_nfb_reg_addr_wr_en <= 1'b0;
      rca_io_inp_map_wr_en   <= 1'b0;
      cpu_src_dest_port      <= 1'b0;
      done                   <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            rca_sel_issue <= rca_id;
            cfg_error     <= 1'b0;
            cnt           <= '0;
            state         <= grid_busy ? WAIT_GRID : RUN;
          end
        WAIT_GRID:
          if (abort) state <= IDLE;
          else if (!grid_busy) state <= RUN;
        RUN:
          if (abort) state <= IDLE;
          else if (accept) begin
            if (kind == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!legal || full) begin
              cfg_error <= 1'b1;
              state     <= IDLE;
            end else begin
              grid_mux_wr_en         <= kind == 3'd0;
              io_mux_wr_en           <= kind == 3'd1;
              rca_result_mux_wr_en   <= kind == 3'd2;
              cpu_fb_reg_addr_wr_en  <= kind == 3'd3 || kind == 3'd4;
              cpu_nfb_reg_addr_wr_en <= kind == 3'd5;
              rca_io_inp_map_wr_en   <= kind == 3'd6;
              cpu_src_dest_port      <= kind == 3'd4 || kind == 3'd5;
              wr_addr                <= cfg.cfg_data[23:16];
              wr_data                <= cfg.cfg_data[15:0];
              cnt                    <= cnt + CW'(1);
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rca_config_loader.sv
// tb_rca_config_loader: scoreboard bench for rca_config_loader built with MAX_CFG_WORDS=4
module tb_rca_config_loader;
  logic        clk = 0, rst = 0, start = 0, abort = 0, grid_busy = 0;
  logic [1:0]  rca_id = 0, rca_sel_issue;
  logic        grid_mux_wr_en, io_mux_wr_en, rca_result_mux_wr_en;
  logic        cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en, rca_io_inp_map_wr_en;
  logic        cpu_src_dest_port, busy, done, cfg_error;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  typedef logic [30:0] exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, m_cnt = 0;
  rca_config_loader_if cfg_if();
  rca_config_loader #(.MAX_CFG_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rca_id(rca_id), .abort(abort),
    .grid_busy(grid_busy), .cfg(cfg_if.slave), .rca_sel_issue(rca_sel_issue),
    .grid_mux_wr_en(grid_mux_wr_en), .io_mux_wr_en(io_mux_wr_en),
    .rca_result_mux_wr_en(rca_result_mux_wr_en),
    .cpu_fb_reg_addr_wr_en(cpu_fb_reg_addr_wr_en),
    .cpu_nfb_reg_addr_wr_en(cpu_nfb_reg_addr_wr_en),
    .rca_io_inp_map_wr_en(rca_io_inp_map_wr_en),
    .cpu_src_dest_port(cpu_src_dest_port), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({rca_sel_issue, grid_mux_wr_en, io_mux_wr_en, rca_result_mux_wr_en,
                cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en, rca_io_inp_map_wr_en,
                cpu_src_dest_port, wr_addr, wr_data, busy, done, cfg_error, cfg_if.cfg_ready});
  endfunction
  function automatic logic [5:0] strobes();
    return {grid_mux_wr_en, io_mux_wr_en, rca_result_mux_wr_en,
            cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en, rca_io_inp_map_wr_en};
  endfunction
  function automatic exp_t mk(input logic [2:0] k, input logic [7:0] a, input logic [15:0] d);
    logic [5:0] s;
    s = k == 0 ? 6'b100000 : k == 1 ? 6'b010000 : k == 2 ? 6'b001000 :
        (k == 3 || k == 4) ? 6'b000100 : k == 5 ? 6'b000010 : 6'b000001;
    return {s, k == 4 || k == 5, a, d};
  endfunction
  function automatic bit legal(input logic [2:0] k, input logic [7:0] a, input logic [15:0] d);
    int ai, di;
    ai = int'(a);
    di = int'(d);
    case (k)
      0: return ai < 64 && di < 16;
      1: return ai < 5 && di < 16;
      2: return ai < 5 && di < 5;
      3, 4, 5: return ai < 5 && di < 32;
      6: return di < 32;
      default: return 1;
    endcase
  endfunction
  always @(negedge clk) begin
    logic [5:0] s;
    s = strobes();
    check("onehot", 64'($countones(s) <= 1), 64'd1);
    if (s != 0) begin
      if (q.size() == 0) check("unexpected_strobe", 64'({s, cpu_src_dest_port, wr_addr, wr_data}), 64'd0);
      else check("strobe", 64'({s, cpu_src_dest_port, wr_addr, wr_data}), 64'(q.pop_front()));
    end
  end
  task automatic do_start(input logic [1:0] id, input logic gb);
    grid_busy = gb;
    rca_id = id;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    m_cnt = 0;
  endtask
  task automatic send(input logic [2:0] k, input logic [7:0] a, input logic [15:0] d);
    bit ok;
    ok = k == 7 || (legal(k, a, d) && m_cnt < 4);
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_data = {k, 5'b0, a, d};
    for (int i = 0; i < 20; i++) begin
      if (cfg_if.cfg_ready) begin
        if (k != 7 && ok) begin
          q.push_back(mk(k, a, d));
          m_cnt++;
        end
        @(posedge clk); #1;
        cfg_if.cfg_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 64'd0, 64'd1);
    cfg_if.cfg_valid = 0;
  endtask
  task automatic fin(input string tag);
    send(7, 0, 0);
    check({tag, "_done"}, 64'({done, busy}), 64'b11);
    @(posedge clk); #1;
    check({tag, "_idle"}, 64'({done, busy}), 64'b00);
  endtask
  initial begin
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 64'd0);
    rst = 1;
    @(posedge clk); #1;
    check("post_reset", outs(), 64'd0);
    do_start(2, 0);
    check("t1_sel", 64'(rca_sel_issue), 64'd2);
    check("t1_ready", 64'(cfg_if.cfg_ready), 64'd1);
    send(0, 5, 9);
    check("t1_grid", 64'({grid_mux_wr_en, wr_addr, wr_data}), 64'({1'b1, 8'd5, 16'd9}));
    fin("t1");
    check("t1_sel_hold", 64'(rca_sel_issue), 64'd2);
    do_start(1, 1);
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_data = {3'd0, 5'b0, 8'd3, 16'd4};
    repeat (4) begin
      check("t2_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
      @(posedge clk); #1;
    end
    grid_busy = 0;
    check("t2_wait", 64'({cfg_if.cfg_ready, busy}), 64'b01);
    q.push_back(mk(0, 3, 4));
    m_cnt++;
    @(posedge clk); #1;
    check("t2_run", 64'({cfg_if.cfg_ready, grid_mux_wr_en}), 64'b10);
    @(posedge clk); #1;
    cfg_if.cfg_valid = 0;
    check("t2_strobe", 64'(grid_mux_wr_en), 64'd1);
    fin("t2");
    do_start(3, 0);
    send(3, 1, 7);
    send(4, 0, 10);
    send(5, 2, 11);
    send(6, 0, 16'h13);
    check("t3_map", 64'({rca_io_inp_map_wr_en, wr_data}), 64'({1'b1, 16'h13}));
    fin("t3");
    do_start(0, 0);
    send(2, 5, 1);
    check("t4_err", 64'({cfg_error, busy, strobes()}), 64'({2'b10, 6'b0}));
    @(posedge clk); #1;
    check("t4_sticky", 64'(cfg_error), 64'd1);
    do_start(0, 0);
    check("t4_clr", 64'({cfg_error, busy}), 64'b01);
    send(2, 4, 4);
    fin("t4");
    do_start(1, 0);
    for (int i = 0; i < 4; i++) send(0, 8'(10 + i), 16'(i));
    send(0, 20, 1);
    check("t5_max_err", 64'({cfg_error, busy}), 64'b10);
    do_start(1, 0);
    for (int i = 0; i < 4; i++) send(0, 8'(30 + i), 16'(15 - i));
    fin("t5");
    check("t5_no_err", 64'(cfg_error), 64'd0);
    do_start(2, 0);
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_data = {3'd1, 5'b0, 8'd1, 16'd2};
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    cfg_if.cfg_valid = 0;
    check("t6_abort", 64'({busy, done, cfg_error, cfg_if.cfg_ready, strobes()}), 64'd0);
    do_start(3, 0);
    send(0, 2, 3);
    check("t6_pre", 64'(grid_mux_wr_en), 64'd1);
    void'(q.pop_back());
    #1 rst = 0;
    #1 check("t6_async_rst", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("t6_after_rst", outs(), 64'd0);
    check("q_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
